// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared constants, entry record and decode helper for the write-back arbiter
package wb_pkg;

  localparam int WB_DEPTH = 2;
  localparam int REG_AW   = 5;

  // Packed as {a3, wd, pc}: 69 bits.
  typedef struct packed {
    logic [REG_AW-1:0] a3;
    logic [31:0]       wd;
    logic [31:0]       pc;
  } wb_entry_t;

  function automatic logic [31:0] reg_onehot(input logic [REG_AW-1:0] a3);
    reg_onehot = 32'd1 << a3;
  endfunction

endpackage

// File: rtl/wb_fifo2.sv
// rtl/wb_fifo2.sv - 2-entry compacting FIFO with kill-by-register-index
module wb_fifo2
  import wb_pkg::*;
(
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  wb_entry_t                  push_entry,
  input  logic                       pop,
  input  logic                       kill_en,
  input  logic [REG_AW-1:0]          kill_a3,
  output wb_entry_t                  head,
  output logic [1:0]                 cnt,
  output logic [1:0]                 ent_valid,
  output logic [1:0][REG_AW-1:0]     ent_a3
);

  wb_entry_t  mem_q [2];
  wb_entry_t  mem_d [2];
  logic [1:0] cnt_q;
  logic [1:0] cnt_d;
  logic [1:0] keep;
  logic [1:0] kept;

  always_comb begin
    ent_valid[0] = (cnt_q != 2'd0);
    ent_valid[1] = (cnt_q == 2'd2);
    ent_a3[0]    = mem_q[0].a3;
    ent_a3[1]    = mem_q[1].a3;
    head         = mem_q[0];
    cnt          = cnt_q;
  end

  // Survivors are compacted towards slot 0 so the head is always the oldest live entry.
  always_comb begin
    mem_d = mem_q;
    kept  = 2'd0;
    keep[0] = ent_valid[0] && !pop && !(kill_en && (mem_q[0].a3 == kill_a3));
    keep[1] = ent_valid[1] && !(kill_en && (mem_q[1].a3 == kill_a3));
    case (keep)
      2'b11: begin
        kept = 2'd2;
      end
      2'b01: begin
        kept = 2'd1;
      end
      2'b10: begin
        mem_d[0] = mem_q[1];
        kept     = 2'd1;
      end
      default: begin
        kept = 2'd0;
      end
    endcase
    cnt_d = kept;
    if (push && (kept == 2'd0)) begin
      mem_d[0] = push_entry;
      cnt_d    = 2'd1;
    end else if (push && (kept == 2'd1)) begin
      mem_d[1] = push_entry;
      cnt_d    = 2'd2;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q    <= 2'd0;
      mem_q[0] <= '0;
      mem_q[1] <= '0;
    end else begin
      cnt_q    <= cnt_d;
      mem_q[0] <= mem_d[0];
      mem_q[1] <= mem_d[1];
    end
  end

endmodule

// File: rtl/w_wb_arbiter.sv
// rtl/w_wb_arbiter.sv - W-stage / secondary write-back arbiter onto the single GRF write port
// Optional WB_BYPASS_EN: an accepted secondary write skips the empty FIFO when the pipe is idle.
module w_wb_arbiter
  import wb_pkg::*;
#(
  parameter int DEPTH = WB_DEPTH,
  parameter int AW    = REG_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pipe_we,
  input  logic [AW-1:0] pipe_a3,
  input  logic [31:0]   pipe_wd,
  input  logic [31:0]   pipe_pc,
  input  logic          sec_valid,
  output logic          sec_ready,
  input  logic [AW-1:0] sec_a3,
  input  logic [31:0]   sec_wd,
  input  logic [31:0]   sec_pc,
  output logic          grf_we,
  output logic [AW-1:0] grf_a3,
  output logic [31:0]   grf_wd,
  output logic [31:0]   grf_pc,
  output logic [31:0]   pend_mask,
  output logic [1:0]    fifo_cnt
);

  localparam logic [1:0] DEPTH_W = 2'(DEPTH);

  logic                   pipe_eff;
  logic                   sec_fire;
  logic                   sec_keep;
  logic                   bypass;
  logic                   push;
  logic                   pop;
  wb_entry_t              head;
  logic [1:0]             ent_valid;
  logic [1:0][REG_AW-1:0] ent_a3;

  // Ready looks only at the stored count so producers never see a path from their own valid.
  assign sec_ready = (fifo_cnt < DEPTH_W);

  always_comb begin
    pipe_eff = pipe_we && (pipe_a3 != '0);
    sec_fire = sec_valid && sec_ready;
    // A same-cycle pipe write to the same register is younger, so the secondary value is dead.
    sec_keep = sec_fire && (sec_a3 != '0) && !(pipe_eff && (sec_a3 == pipe_a3));
`ifdef WB_BYPASS_EN
    bypass   = sec_keep && !pipe_eff && (fifo_cnt == 2'd0);
`else
    bypass   = 1'b0;
`endif
    push     = sec_keep && !bypass;
    pop      = !pipe_eff && (fifo_cnt != 2'd0);
  end

  always_comb begin
    grf_we = 1'b0;
    grf_a3 = '0;
    grf_wd = 32'd0;
    grf_pc = 32'd0;
    if (pipe_eff) begin
      grf_we = 1'b1;
      grf_a3 = pipe_a3;
      grf_wd = pipe_wd;
      grf_pc = pipe_pc;
    end else if (fifo_cnt != 2'd0) begin
      grf_we = 1'b1;
      grf_a3 = head.a3;
      grf_wd = head.wd;
      grf_pc = head.pc;
    end else if (bypass) begin
      grf_we = 1'b1;
      grf_a3 = sec_a3;
      grf_wd = sec_wd;
      grf_pc = sec_pc;
    end
  end

  always_comb begin
    pend_mask = 32'd0;
    for (int i = 0; i < 2; i++) begin
      if (ent_valid[i]) begin
        pend_mask = pend_mask | reg_onehot(ent_a3[i]);
      end
    end
  end

  wb_fifo2 u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (push),
    .push_entry (wb_entry_t'({sec_a3, sec_wd, sec_pc})),
    .pop        (pop),
    .kill_en    (pipe_eff),
    .kill_a3    (pipe_a3),
    .head       (head),
    .cnt        (fifo_cnt),
    .ent_valid  (ent_valid),
    .ent_a3     (ent_a3)
  );

endmodule
